// File: rtl/gpio_pkg.sv
// Shared constants and types for the Avalon-MM GPIO port: register map,
// edge polarity encoding and the warm-up state type.
package gpio_pkg;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_DIRECTION    = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_OUTSET       = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;
    localparam logic [2:0] ADDR_EDGE_SEL     = 3'd6;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } warm_state_e;

endpackage

// File: rtl/avalon_gpio_port_if.sv
// Avalon-MM slave bus of the GPIO port.
// Handshake: a write is accepted on any clk edge with chipselect && !write_n
// (no wait states); readdata is valid every cycle and holds the register
// addressed at the previous edge, independent of chipselect.
interface avalon_gpio_port_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/gpio_sync_edge.sv
// Multi-stage pin synchroniser plus one history flop, producing the
// synchronised pin value and per-bit rise/fall pulses.
module gpio_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;

    // Stage 0 samples the raw pin; the last stage is the first safe value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign rise    = sync_in & ~prev_q;
    assign fall    = ~sync_in & prev_q;

endmodule

// File: rtl/avalon_gpio_port.sv
// Parametrised Avalon-MM GPIO port: output data with atomic set/clear,
// direction, per-bit edge capture with polarity select and a masked irq.
module avalon_gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    avalon_gpio_port_if.slave        bus,
    input  logic [WIDTH-1:0]         in_port,
    output logic [WIDTH-1:0]         out_port,
    output logic [WIDTH-1:0]         oe,
    output logic                     irq,
    output warm_state_e              dbg_state
);

    localparam logic [2:0] WARM_LAST = 3'(SYNC_STAGES);

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] direction;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] sync_in, rise, fall;
    logic [WIDTH-1:0] edge_raw, edge_gated, clr;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             unused_writedata;
    warm_state_e      state;
    logic [2:0]       warm_cnt;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .sync_in (sync_in),
        .rise    (rise),
        .fall    (fall)
    );

    assign wr_en            = bus.chipselect && !bus.write_n;
    assign wdata            = bus.writedata[WIDTH-1:0];
    assign unused_writedata = ^bus.writedata;

    always_comb begin
        edge_raw = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edge_raw[i] = (edge_sel[i] == EDGE_FALL) ? fall[i] : rise[i];
        end
    end

    // Edges are ignored until the synchroniser and prev flop hold real pin data.
    assign edge_gated = (state == RUN) ? edge_raw : '0;
    assign clr        = (wr_en && bus.address == ADDR_EDGE_CAPTURE) ? wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= WARMUP;
            warm_cnt <= '0;
        end else if (state == WARMUP) begin
            if (warm_cnt == WARM_LAST) begin
                state <= RUN;
            end else begin
                warm_cnt <= warm_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out  <= '0;
            direction <= '0;
            irq_mask  <= '0;
            edge_sel  <= '0;
            capture   <= '0;
        end else begin
            if (wr_en) begin
                case (bus.address)
                    ADDR_DATA:      data_out  <= wdata;
                    ADDR_DIRECTION: direction <= wdata;
                    ADDR_IRQ_MASK:  irq_mask  <= wdata;
                    ADDR_OUTSET:    data_out  <= data_out | wdata;
                    ADDR_OUTCLEAR:  data_out  <= data_out & ~wdata;
                    ADDR_EDGE_SEL:  edge_sel  <= wdata;
                    default: ;
                endcase
            end
            // A new edge wins over a same-cycle W1C of that bit.
            capture <= (capture & ~clr) | edge_gated;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:         rd_mux = 32'(sync_in);
            ADDR_DIRECTION:    rd_mux = 32'(direction);
            ADDR_IRQ_MASK:     rd_mux = 32'(irq_mask);
            ADDR_EDGE_CAPTURE: rd_mux = 32'(capture);
            ADDR_EDGE_SEL:     rd_mux = 32'(edge_sel);
            default:           rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

    assign out_port  = data_out;
    assign oe        = direction;
    assign irq       = |(capture & irq_mask);
    assign dbg_state = state;

endmodule
